dmem_responder: RTL and testbench

//  Data-memory responder: the target side of the core's load/store port, replacing the zero-latency array.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e    : FSM state encoding (IDLE/WAIT/RESP)
//   WAIT_CNT_W : width of the wait-state down-counter (WAIT range 0..15)
package dmem_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: 2**ADDR_W x 32 bits.
// Ports:
//   clk   : write clock
//   we    : synchronous write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : combinational read data (registered by the caller)
// Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the core's load/store port.
// Accepts one request at a time (req/ack), inserts WAIT wait states, then
// performs the word read or write and pulses ack for one cycle.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req        : request valid, sampled only while idle
//   we         : 1 = store, 0 = load (sampled with req)
//   addr       : byte address, bits [1:0] ignored
//   wdata      : store data (sampled with req)
//   rdata      : registered load data, updated only by completed loads
//   ack        : one-cycle completion pulse
//   busy       : request in flight
//   err        : out-of-range flag, qualified by ack
// Configuration: define DMEM_RANGE_CHECK_EN to flag accesses with nonzero
// address bits above the RAM (store suppressed, load returns 0, err=1).
// Without it those bits are ignored and addresses alias; err is tied 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  state_e                state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  we_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [31:0]           wdata_q;
  logic                  oor_q;

  logic [ADDR_W-1:0]     in_idx;
  logic                  in_oor;
  logic                  idle;
  logic                  cur_we;
  logic [ADDR_W-1:0]     cur_idx;
  logic [31:0]           cur_wdata;
  logic                  cur_oor;
  logic                  go_resp;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
  logic                  unused_addr;

  assign in_idx      = addr[ADDR_W+1:2];
  assign unused_addr = ^{addr[1:0], addr[31:ADDR_W+2]};

`ifdef DMEM_RANGE_CHECK_EN
  assign in_oor = |addr[31:ADDR_W+2];
`else
  assign in_oor = 1'b0;
`endif

  // With WAIT=0 the access happens on the accepting edge, so the live inputs
  // are used instead of the latches that are being loaded on that same edge.
  assign idle      = (state == S_IDLE);
  assign cur_we    = idle ? we     : we_q;
  assign cur_idx   = idle ? in_idx : idx_q;
  assign cur_wdata = idle ? wdata  : wdata_q;
  assign cur_oor   = idle ? in_oor : oor_q;

  // True on the edge that enters RESP.
  assign go_resp = (idle && req && (WAIT == 0)) || ((state == S_WAIT) && (cnt == '0));
  assign mem_we  = go_resp && cur_we && !cur_oor;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (cur_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata   <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (go_resp) begin
        ack <= 1'b1;
        err <= cur_oor;
        if (!cur_we) begin
          rdata <= cur_oor ? '0 : mem_rdata;
        end
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            idx_q   <= in_idx;
            wdata_q <= wdata;
            oor_q   <= in_oor;
            busy    <= 1'b1;
            if (WAIT == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_CNT_W'(WAIT - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT=2 and WAIT=0) share clock and
// reset; a per-instance word array tracks expected RAM contents.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned W_A    = 2;
  localparam int unsigned W_B    = 0;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        busy  [2];
  logic        err   [2];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ack_cnt [2] = '{0, 0};
  int          n_acc   [2] = '{0, 0};
  logic [31:0] model   [2][DEPTH];
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset && ack[d] === 1'b1) ack_cnt[d] = ack_cnt[d] + 1;
    end
  end

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT(W_A)) u_w2 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0])
  );

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT(W_B)) u_w0 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? int'(W_A) : int'(W_B);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access; returns the cycle number of the ack cycle.
  task automatic access(input int d, input bit st, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output int ack_at);
    int          w;
    int          guard;
    int          idx;
    bit          oor;
    logic [31:0] exp_rd;
    w     = wait_of(d);
    idx   = int'((a >> 2) % DEPTH);
    oor   = RANGE_EN && ((a >> (ADDR_W + 2)) != 0);
    guard = 0;
    @(negedge clk);
    while (busy[d] !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_before_req", {31'b0, busy[d]}, 32'h0);
    req[d]   = 1'b1;
    we[d]    = st;
    addr[d]  = a;
    wdata[d] = wd;
    @(posedge clk);
    #1;
    if (!hold) req[d] = 1'b0;
    // Inputs are free to change once accepted.
    we[d]    = 1'($urandom);
    addr[d]  = $urandom;
    wdata[d] = $urandom;
    for (int i = 0; i < w; i++) begin
      chk("ack_low_in_wait", {31'b0, ack[d]}, 32'h0);
      chk("busy_in_wait", {31'b0, busy[d]}, 32'h1);
      @(posedge clk);
      #1;
    end
    chk("ack_pulse", {31'b0, ack[d]}, 32'h1);
    chk("err_with_ack", {31'b0, err[d]}, {31'b0, oor});
    if (st) begin
      if (!oor) model[d][idx] = wd;
      chk("rdata_hold_on_store", rdata[d], last_rd[d]);
    end else begin
      exp_rd     = oor ? 32'h0 : model[d][idx];
      last_rd[d] = exp_rd;
      chk("load_rdata", rdata[d], exp_rd);
    end
    n_acc[d]++;
    ack_at = cyc;
  endtask

  initial begin
    int          t1;
    int          t2;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rdata", rdata[d], 32'h0);
      chk("reset_ack", {31'b0, ack[d]}, 32'h0);
      chk("reset_busy", {31'b0, busy[d]}, 32'h0);
      chk("reset_err", {31'b0, err[d]}, 32'h0);
    end
    reset = 1'b0;

    // Fill both RAMs with known contents
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(DEPTH); i++) access(d, 1'b1, 32'(i * 4), $urandom, 1'b0, t1);
    end

    // Reset during WAIT: store dropped, no ack, outputs cleared at once
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = ~model[0][8];
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, busy[0]}, 32'h0);
    chk("rst_mid_ack", {31'b0, ack[0]}, 32'h0);
    chk("rst_mid_rdata", rdata[0], 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    access(0, 1'b0, 32'h20, 32'h0, 1'b0, t1);

    // Store/load with WAIT=2, back-to-back period WAIT+2
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, t1);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, t2);
    chk("period_wait2", 32'(t2 - t1), 32'(W_A + 2));

    // WAIT=0: ack the cycle after acceptance, period 2
    access(1, 1'b1, 32'h4, 32'h12345678, 1'b0, t1);
    access(1, 1'b0, 32'h4, 32'h0, 1'b0, t2);
    chk("period_wait0", 32'(t2 - t1), 32'(W_B + 2));

    // req held high through RESP: next access taken in the following IDLE cycle
    access(0, 1'b1, 32'h2C, 32'h0BADF00D, 1'b1, t1);
    access(0, 1'b0, 32'h2C, 32'h0, 1'b0, t2);
    chk("period_held_req", 32'(t2 - t1), 32'(W_A + 2));
    access(1, 1'b1, 32'h30, 32'hCAFE0001, 1'b1, t1);
    access(1, 1'b0, 32'h30, 32'h0, 1'b0, t2);
    chk("period_held_req0", 32'(t2 - t1), 32'(W_B + 2));

    // Upper address bits: alias without range check, flagged with it
    access(0, 1'b1, 32'h100, 32'hA5A5A5A5, 1'b0, t1);
    access(0, 1'b0, 32'h0, 32'h0, 1'b0, t1);

    // Randomized mix against the model
    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      if ($urandom_range(1, 0) == 0) a = a & 32'hFF;
      access(n % 2, 1'($urandom), a, $urandom, 1'($urandom), t1);
      req[n % 2] = 1'b0;
    end

    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ack_count", 32'(ack_cnt[d]), 32'(n_acc[d]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
